// File: rtl/ccs_mc_pkg_hdl.sv
// Shared types, defaults and the round-robin search for the multi-channel CCS merge FIFO.
package ccs_mc_pkg_hdl;

  typedef enum logic {CCS_MC_ARB, CCS_MC_HOLD} ccs_mc_arb_state_t;

  localparam int CCS_MC_WIDTH_DEF  = 32;
  localparam int CCS_MC_NUM_CH_DEF = 4;
  localparam int CCS_MC_DEPTH_DEF  = 4;
  localparam int CCS_MC_MAX_CH     = 16;

  // First requester at or after ptr, wrapping at num_ch; returns ptr when nothing requests.
  function automatic logic [3:0] ccs_mc_rr_next(input logic [3:0] ptr,
                                                input logic [CCS_MC_MAX_CH-1:0] req,
                                                input int num_ch);
    logic [3:0] win;
    logic       found;
    int         idx;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < CCS_MC_MAX_CH; i++) begin
      idx = (int'(ptr) + i) % num_ch;
      if (!found && (i < num_ch) && req[idx]) begin
        win   = 4'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ccs_mc_chan_fifo.sv
// Single-channel CCS FIFO: registered count, no pass-through, flush beats push/pop.
module ccs_mc_chan_fifo
  import ccs_mc_pkg_hdl::*;
#(
  parameter int WIDTH = CCS_MC_WIDTH_DEF,
  parameter int DEPTH = CCS_MC_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ccs_mc_merge_fifo.sv
// NUM_CH-way CCS merge: per-channel FIFOs, round-robin arbiter with hold lock, tagged output.
// Define CCS_MC_MERGE_OCC_EN to add occ/hwm per-channel occupancy and high-water-mark ports.
module ccs_mc_merge_fifo
  import ccs_mc_pkg_hdl::*;
#(
  parameter int WIDTH  = CCS_MC_WIDTH_DEF,
  parameter int NUM_CH = CCS_MC_NUM_CH_DEF,
  parameter int DEPTH  = CCS_MC_DEPTH_DEF,
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    flush,
  input  logic [NUM_CH-1:0]       in_vld,
  output logic [NUM_CH-1:0]       in_rdy,
  input  logic [NUM_CH*WIDTH-1:0] in_dat,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [WIDTH-1:0]        out_dat,
  output logic [CH_W-1:0]         out_ch
`ifdef CCS_MC_MERGE_OCC_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] occ,
  output logic [NUM_CH*CNT_W-1:0] hwm
`endif
);

  ccs_mc_arb_state_t           state_q, state_d;
  logic [CH_W-1:0]             rr_ptr_q, rr_ptr_d, lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]             grant, rr_grant;
  logic [NUM_CH-1:0]           full, empty, nonempty, push, pop;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0][WIDTH-1:0] head;
  logic                        xfer;

  function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
    return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ccs_mc_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .arst_n(arst_n),
      .flush (flush),
      .push  (push[c]),
      .pop   (pop[c]),
      .din   (in_dat[c*WIDTH +: WIDTH]),
      .full  (full[c]),
      .empty (empty[c]),
      .count (cnt[c]),
      .head  (head[c])
    );
  end

  assign nonempty = ~empty;
  assign rr_grant = CH_W'(ccs_mc_rr_next(4'(rr_ptr_q), CCS_MC_MAX_CH'(nonempty), NUM_CH));
  assign in_rdy   = flush ? '1 : ~full;
  assign push     = in_vld & ~full;
  assign pop      = (xfer && !flush) ? (NUM_CH'(1) << grant) : '0;
  assign out_dat  = head[grant];
  assign out_ch   = grant;

  // Once offered, the locked channel keeps the output so data/tag stay stable until taken.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_ch_d = lock_ch_q;
    if (state_q == CCS_MC_HOLD) begin
      grant   = lock_ch_q;
      out_vld = (cnt[lock_ch_q] != '0);
    end else begin
      grant   = rr_grant;
      out_vld = |nonempty;
    end
    xfer = out_vld & out_rdy;
    if (flush) begin
      state_d   = CCS_MC_ARB;
      rr_ptr_d  = '0;
      lock_ch_d = '0;
    end else if (xfer) begin
      state_d  = CCS_MC_ARB;
      rr_ptr_d = ch_inc(grant);
    end else if (out_vld) begin
      state_d   = CCS_MC_HOLD;
      lock_ch_d = grant;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= CCS_MC_ARB;
      rr_ptr_q  <= '0;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_ch_q <= lock_ch_d;
    end
  end

`ifdef CCS_MC_MERGE_OCC_EN
  logic [NUM_CH-1:0][CNT_W-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (flush)                hwm_d[c] = '0;
      else if (cnt[c] > hwm_q[c]) hwm_d[c] = cnt[c];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) hwm_q <= '0;
    else         hwm_q <= hwm_d;
  end

  assign occ = cnt;
  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_ccs_mc_merge_fifo.sv
// Directed bench for ccs_mc_merge_fifo with a queue-level reference model checked every cycle.
module tb_ccs_mc_merge_fifo;
  localparam int W = 32, N = 4, D = 4, CW = 2, CNW = 3;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic           flush = 1'b0;
  logic [N-1:0]   in_vld = '0;
  logic [N-1:0]   in_rdy;
  logic [N*W-1:0] in_dat = '0;
  logic           out_vld;
  logic           out_rdy = 1'b0;
  logic [W-1:0]   out_dat;
  logic [CW-1:0]  out_ch;
`ifdef CCS_MC_MERGE_OCC_EN
  logic [N*CNW-1:0] occ, hwm;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  ccs_mc_merge_fifo #(.WIDTH(W), .NUM_CH(N), .DEPTH(D)) dut (
    .clk(clk), .arst_n(arst_n), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_ch(out_ch)
`ifdef CCS_MC_MERGE_OCC_EN
    , .occ(occ), .hwm(hwm)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int c, input logic [31:0] v);
    in_vld[c] = 1'b1;
    in_dat[c*W +: W] = v;
  endtask

  // Reference model: plain queues per channel, a round-robin pointer and a locked channel.
  logic [31:0] mq [N][$];
  int          m_rr;
  int          m_lock;

  always @(negedge clk) begin
    int  ech;
    bit  ev;
    bit  [N-1:0] acc;
    logic [N-1:0] erdy;
    if (!arst_n) begin
      for (int c = 0; c < N; c++) mq[c].delete();
      m_rr = 0;
      m_lock = -1;
    end else if (chk_en) begin
      ev = 1'b0;
      ech = 0;
      if (m_lock >= 0) begin
        ev = 1'b1;
        ech = m_lock;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!ev && mq[(m_rr + i) % N].size() > 0) begin
            ev = 1'b1;
            ech = (m_rr + i) % N;
          end
        end
      end
      for (int c = 0; c < N; c++) erdy[c] = flush || (mq[c].size() < D);
      check("m_in_rdy", 32'(in_rdy), 32'(erdy));
      check("m_out_vld", 32'(out_vld), 32'(ev));
      if (ev) begin
        check("m_out_ch", 32'(out_ch), 32'(ech));
        check("m_out_dat", out_dat, mq[ech][0]);
      end
      if (flush) begin
        for (int c = 0; c < N; c++) mq[c].delete();
        m_rr = 0;
        m_lock = -1;
      end else begin
        for (int c = 0; c < N; c++) acc[c] = in_vld[c] && (mq[c].size() < D);
        if (ev && out_rdy) begin
          void'(mq[ech].pop_front());
          m_rr = (ech + 1) % N;
          m_lock = -1;
        end else if (ev) begin
          m_lock = ech;
        end
        for (int c = 0; c < N; c++) if (acc[c]) mq[c].push_back(in_dat[c*W +: W]);
      end
    end
  end

  initial begin
    // reset values
    #12;
    check("rst_in_rdy", 32'(in_rdy), 32'hF);
    check("rst_out_vld", 32'(out_vld), 32'h0);
    check("rst_out_ch", 32'(out_ch), 32'h0);
    check("rst_out_dat", out_dat, 32'h0);
    cyc();
    arst_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // single word on ch2, one-cycle latency
    out_rdy = 1'b1;
    put(2, 32'hA5A5_0001);
    check("t1_no_passthru", 32'(out_vld), 32'h0);
    cyc();
    in_vld = '0;
    check("t1_vld", 32'(out_vld), 32'h1);
    check("t1_dat", out_dat, 32'hA5A5_0001);
    check("t1_ch", 32'(out_ch), 32'h2);
    check("t1_rdy", 32'(in_rdy), 32'hF);
    cyc();
    check("t1_drained", 32'(out_vld), 32'h0);

    // fill ch0, 5th word refused
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(0, 32'h100 + i);
      cyc();
    end
    check("t2_full_rdy", 32'(in_rdy), 32'hE);
    put(0, 32'h1FF);
    cyc();
    in_vld = '0;
    check("t2_still_full", 32'(in_rdy), 32'hE);
    check("t2_ch", 32'(out_ch), 32'h0);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_dat", out_dat, 32'h100 + i);
      cyc();
    end
    check("t2_no_5th", 32'(out_vld), 32'h0);

    // flush to rr_ptr=0, then 2 words per channel, round-robin back-to-back
    out_rdy = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) put(c, 32'h3000_0000 + 32'(c * 16 + k));
      cyc();
    end
    in_vld = '0;
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t3_vld", 32'(out_vld), 32'h1);
      check("t3_ch", 32'(out_ch), 32'(i % 4));
      check("t3_dat", out_dat, 32'h3000_0000 + 32'((i % 4) * 16 + i / 4));
      cyc();
    end
    check("t3_empty", 32'(out_vld), 32'h0);

    // hold lock on ch3 while ch0 arrives with rr_ptr=0
    out_rdy = 1'b0;
    put(3, 32'h4000_0003);
    cyc();
    in_vld = '0;
    cyc();
    put(0, 32'h4000_0000);
    cyc();
    in_vld = '0;
    check("t4_hold_ch", 32'(out_ch), 32'h3);
    check("t4_hold_dat", out_dat, 32'h4000_0003);
    cyc();
    check("t4_hold_ch2", 32'(out_ch), 32'h3);
    out_rdy = 1'b1;
    cyc();
    check("t4_next_ch", 32'(out_ch), 32'h0);
    check("t4_next_dat", out_dat, 32'h4000_0000);
    cyc();

    // full ch1, simultaneous pop and offered write
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(1, 32'h5000_0000 + i);
      cyc();
    end
    put(1, 32'h5000_00AA);
    out_rdy = 1'b1;
    check("t5_full", 32'(in_rdy), 32'hD);
    cyc();
    check("t5_after_pop_rdy", 32'(in_rdy), 32'hF);
    check("t5_head", out_dat, 32'h5000_0001);
`ifdef CCS_MC_MERGE_OCC_EN
    check("t5_occ3", 32'(occ[1*CNW +: CNW]), 32'h3);
`endif
    out_rdy = 1'b0;
    cyc();
    in_vld = '0;
    check("t5_refull", 32'(in_rdy), 32'hD);
    out_rdy = 1'b1;
    check("t5_d1", out_dat, 32'h5000_0001); cyc();
    check("t5_d2", out_dat, 32'h5000_0002); cyc();
    check("t5_d3", out_dat, 32'h5000_0003); cyc();
    check("t5_d4", out_dat, 32'h5000_00AA); cyc();
    check("t5_empty", 32'(out_vld), 32'h0);

    // flush with 3 words on ch1 and a same-cycle write
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1, 32'h6000_0000 + i);
      cyc();
    end
    put(1, 32'h6000_00FF);
    flush = 1'b1;
    check("t6_rdy_flush", 32'(in_rdy), 32'hF);
`ifdef CCS_MC_MERGE_OCC_EN
    check("t6_hwm_pre", 32'(hwm[1*CNW +: CNW]), 32'h4);
`endif
    cyc();
    flush = 1'b0;
    in_vld = '0;
    check("t6_vld", 32'(out_vld), 32'h0);
    check("t6_rdy", 32'(in_rdy), 32'hF);
`ifdef CCS_MC_MERGE_OCC_EN
    check("t6_hwm", 32'(hwm[1*CNW +: CNW]), 32'h0);
    check("t6_occ", 32'(occ), 32'h0);
`endif
    cyc();
    check("t6_dropped", 32'(out_vld), 32'h0);

    // async reset mid-operation
    put(2, 32'h7000_0002);
    cyc();
    in_vld = '0;
    check("t7_vld_pre", 32'(out_vld), 32'h1);
    #2;
    arst_n = 1'b0;
    #1;
    check("t7_rst_vld", 32'(out_vld), 32'h0);
    check("t7_rst_rdy", 32'(in_rdy), 32'hF);
    check("t7_rst_ch", 32'(out_ch), 32'h0);
    cyc();
    arst_n = 1'b1;
    cyc();
    put(1, 32'h7000_0001);
    cyc();
    in_vld = '0;
    check("t7_post_ch", 32'(out_ch), 32'h1);
    check("t7_post_dat", out_dat, 32'h7000_0001);
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
